// File: rtl/gw_video_pkg.sv
// Shared video-path definitions: line-fetch FSM states and image line geometry.
package gw_video_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BURST = 2'd2,
        ST_FLUSH = 2'd3
    } fetch_state_t;

    localparam int BYTES_PER_PIXEL         = 3;
    localparam int DEFAULT_PIXELS_PER_LINE = 720;
    localparam int WORDS_PER_LINE          = DEFAULT_PIXELS_PER_LINE * BYTES_PER_PIXEL;

    // One SDRAM word carries one byte of every plane, so a line needs one word per byte of a pixel.
    function automatic int line_words(input int pixels);
        return pixels * BYTES_PER_PIXEL;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single slow control bit (hblank, vblank) crossing into the local clock.
module bit_sync (
    input  logic clk,
    input  logic srst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous bit through two flops before anyone looks at it.
    always_ff @(posedge clk) begin
        if (srst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sdram_line_fetcher.sv
// Fetches the next image line from SDRAM during hblank and packs byte-interleaved
// background/mask words into 24-bit pixels for the two image FIFOs.
module sdram_line_fetcher
    import gw_video_pkg::*;
#(
    parameter int PIXELS_PER_LINE = DEFAULT_PIXELS_PER_LINE,
    parameter int LINES           = 720,
    parameter int ADDR_WIDTH      = 25
) (
    input  logic                  clk_sys_131_072,
    input  logic                  reset,
    input  logic                  hblank,
    input  logic [9:0]            video_y,
    input  logic                  sd_data_available,
    input  logic [15:0]           sd_q,
    input  logic                  fifo_wrfull,
    output logic                  sd_rd,
    output logic                  sd_end_burst,
    output logic [ADDR_WIDTH-1:0] sd_addr,
    output logic                  fifo_wr,
    output logic [23:0]           background_data,
    output logic [23:0]           mask_data,
    output logic                  overflow
);

    localparam int          WPL    = line_words(PIXELS_PER_LINE);
    localparam logic [15:0] WPL_W  = 16'(WPL);
    // The controller delivers a couple of words after a terminate, so ask two words early.
    localparam logic [15:0] END_AT = 16'(WPL - 2);

    // Word address of the first word of the line after y, wrapping at the last line.
    function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [9:0] y);
        logic [9:0] ny;
        ny = (32'(y) >= 32'(LINES - 1)) ? 10'd0 : y + 10'd1;
        return ADDR_WIDTH'(ny) * ADDR_WIDTH'(WPL);
    endfunction

    fetch_state_t          state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [1:0]            phase_q, phase_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [23:0]           bg_q, bg_d;
    logic [23:0]           mk_q, mk_d;
    logic                  fifo_wr_q, fifo_wr_d;
    logic                  end_burst_q, end_burst_d;
    logic                  avail_prev_q;
    logic                  hblank_prev_q;
    logic                  overflow_q;
    logic                  hblank_sync;
    logic                  hblank_edge;

    bit_sync u_hblank_sync (
        .clk  (clk_sys_131_072),
        .srst (reset),
        .d_i  (hblank),
        .q_o  (hblank_sync)
    );

    assign hblank_edge = hblank_sync & ~hblank_prev_q;

    // Fetch sequencing, word counting and pixel packing; a hblank edge always takes priority over data.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        phase_d     = phase_q;
        base_d      = base_q;
        bg_d        = bg_q;
        mk_d        = mk_q;
        fifo_wr_d   = 1'b0;
        end_burst_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hblank_edge) begin
                    count_d = 16'd0;
                    phase_d = 2'd0;
                    base_d  = line_base(video_y);
                    state_d = ST_REQ;
                end
            end
            ST_REQ, ST_BURST: begin
                if (hblank_edge) begin
                    // Abandon the running line; the new one is latched once the bus drains.
                    end_burst_d = 1'b1;
                    phase_d     = 2'd0;
                    state_d     = ST_FLUSH;
                end else if (state_q == ST_REQ) begin
                    state_d = ST_BURST;
                end else if (sd_data_available) begin
                    if (count_q < WPL_W) begin
                        count_d     = count_q + 16'd1;
                        end_burst_d = (count_q == END_AT);
                        bg_d        = {sd_q[7:0], bg_q[23:8]};
                        mk_d        = {sd_q[15:8], mk_q[23:8]};
                        phase_d     = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
                        fifo_wr_d   = (phase_q == 2'd2);
                    end
                end else if (avail_prev_q) begin
                    // Burst ended: resume where it stopped if the line is still short.
                    state_d = (count_q < WPL_W) ? ST_REQ : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (hblank_edge) begin
                    end_burst_d = 1'b1;
                    phase_d     = 2'd0;
                end else if (!sd_data_available) begin
                    count_d = 16'd0;
                    phase_d = 2'd0;
                    base_d  = line_base(video_y);
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; overflow is sticky until reset.
    always_ff @(posedge clk_sys_131_072) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            count_q       <= 16'd0;
            phase_q       <= 2'd0;
            base_q        <= '0;
            bg_q          <= 24'd0;
            mk_q          <= 24'd0;
            fifo_wr_q     <= 1'b0;
            end_burst_q   <= 1'b0;
            avail_prev_q  <= 1'b0;
            hblank_prev_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            phase_q       <= phase_d;
            base_q        <= base_d;
            bg_q          <= bg_d;
            mk_q          <= mk_d;
            fifo_wr_q     <= fifo_wr_d;
            end_burst_q   <= end_burst_d;
            avail_prev_q  <= sd_data_available;
            hblank_prev_q <= hblank_sync;
            overflow_q    <= overflow_q | (fifo_wr_q & fifo_wrfull);
        end
    end

    assign sd_rd           = (state_q == ST_REQ);
    assign sd_addr         = base_q + ADDR_WIDTH'(count_q);
    assign sd_end_burst    = end_burst_q;
    assign fifo_wr         = fifo_wr_q;
    assign background_data = bg_q;
    assign mask_data       = mk_q;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_sdram_line_fetcher.sv
// Randomized bench: an SDRAM burst model feeds the fetcher, a scoreboard checks every pixel.
module tb_sdram_line_fetcher;
    import gw_video_pkg::*;

    localparam int WPL   = WORDS_PER_LINE;
    localparam int PPL   = DEFAULT_PIXELS_PER_LINE;
    localparam int LINES = 720;
    localparam int AW    = 25;
    localparam int NOCUT = 4000;

    logic          clk = 1'b0;
    logic          reset;
    logic          hblank;
    logic [9:0]    video_y;
    logic          sd_data_available;
    logic [15:0]   sd_q;
    logic          fifo_wrfull;
    logic          sd_rd;
    logic          sd_end_burst;
    logic [AW-1:0] sd_addr;
    logic          fifo_wr;
    logic [23:0]   background_data;
    logic [23:0]   mask_data;
    logic          overflow;

    sdram_line_fetcher dut (
        .clk_sys_131_072   (clk),
        .reset             (reset),
        .hblank            (hblank),
        .video_y           (video_y),
        .sd_data_available (sd_data_available),
        .sd_q              (sd_q),
        .fifo_wrfull       (fifo_wrfull),
        .sd_rd             (sd_rd),
        .sd_end_burst      (sd_end_burst),
        .sd_addr           (sd_addr),
        .fifo_wr           (fifo_wr),
        .background_data   (background_data),
        .mask_data         (mask_data),
        .overflow          (overflow)
    );

    always #4 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] seed     = 32'h1234_5678;
    int          first_cut = NOCUT;
    int          model_n  = 0;
    bit          model_busy = 0;
    int          end_addr = -1;
    int          wr_cnt = 0, rd_cnt = 0, end_cnt = 0;
    int          rd_addr_q[$];
    int          cur_base = 0, pending_base = 0, pix_idx = 0;
    bit          exp_active = 0, switch_pending = 0, in_flush = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // SDRAM contents: a fixed pseudo-random word per address.
    function automatic logic [15:0] mem(input int a);
        logic [31:0] h;
        h = (32'(a) * 32'h9E37_79B1) ^ seed;
        h = h ^ (h >> 15);
        return h[23:8];
    endfunction

    function automatic int exp_base_of(input int y);
        return ((y >= LINES - 1) ? 0 : y + 1) * WPL;
    endfunction

    // SDRAM port model: after sd_rd, stream words from the requested address until the cut
    // length, or two more words after a terminate request.
    initial begin
        int addr, cut, remaining, lat;
        sd_data_available = 1'b0;
        sd_q = 16'd0;
        forever begin
            @(negedge clk);
            if (sd_rd === 1'b1) begin
                addr = int'(sd_addr);
                cut = first_cut;
                first_cut = NOCUT;
                lat = int'($urandom_range(1, 4));
                model_busy = 1;
                model_n = 0;
                remaining = -1;
                repeat (lat) @(negedge clk);
                while (model_n < cut && remaining != 0) begin
                    sd_data_available = 1'b1;
                    sd_q = mem(addr + model_n);
                    model_n++;
                    if (remaining > 0) remaining--;
                    @(negedge clk);
                    if (sd_end_burst === 1'b1 && remaining < 0) begin
                        remaining = 2;
                        end_addr = addr + model_n - 1;
                        $display("burst terminate after word at 0x%0h", end_addr);
                    end
                end
                sd_data_available = 1'b0;
                sd_q = 16'($urandom);
                model_busy = 0;
            end
        end
    end

    // Scoreboard: pixel k of a line is bytes of words base+3k .. base+3k+2, first word lowest.
    initial begin
        logic [15:0] w0, w1, w2;
        forever begin
            @(negedge clk);
            if (fifo_wr === 1'b1) begin
                wr_cnt++;
                if (in_flush) begin
                    check_eq("fifo_wr_in_flush", 32'(fifo_wr), 32'd0);
                end else if (exp_active && pix_idx < PPL) begin
                    w0 = mem(cur_base + 3 * pix_idx);
                    w1 = mem(cur_base + 3 * pix_idx + 1);
                    w2 = mem(cur_base + 3 * pix_idx + 2);
                    check_eq($sformatf("bg_px%0d", pix_idx), 32'(background_data), 32'({w2[7:0], w1[7:0], w0[7:0]}));
                    check_eq($sformatf("mk_px%0d", pix_idx), 32'(mask_data), 32'({w2[15:8], w1[15:8], w0[15:8]}));
                end
                pix_idx++;
            end
            if (sd_rd === 1'b1) begin
                rd_cnt++;
                rd_addr_q.push_back(int'(sd_addr));
                $display("sd_rd addr=%0d", sd_addr);
                in_flush = 0;
            end
            if (sd_end_burst === 1'b1) begin
                end_cnt++;
                if (switch_pending) begin
                    cur_base = pending_base;
                    pix_idx = 0;
                    switch_pending = 0;
                    in_flush = 1;
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        check_eq({tag, "_sd_rd"}, 32'(sd_rd), 32'd0);
        check_eq({tag, "_end_burst"}, 32'(sd_end_burst), 32'd0);
        check_eq({tag, "_sd_addr"}, 32'(sd_addr), 32'd0);
        check_eq({tag, "_fifo_wr"}, 32'(fifo_wr), 32'd0);
        check_eq({tag, "_bg"}, 32'(background_data), 32'd0);
        check_eq({tag, "_mk"}, 32'(mask_data), 32'd0);
        check_eq({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    task automatic start_line(input int y, input int cut, input string tag);
        int k;
        @(negedge clk);
        video_y = 10'(y);
        cur_base = exp_base_of(y);
        pix_idx = 0;
        exp_active = 1;
        first_cut = cut;
        seed = $urandom;
        wr_cnt = 0; rd_cnt = 0; end_cnt = 0; end_addr = -1;
        rd_addr_q.delete();
        hblank = 1'b1;
        for (k = 1; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (sd_rd === 1'b1) break;
        end
        check_eq({tag, "_latency"}, 32'(k), 32'd3);
        repeat (3) @(negedge clk);
        hblank = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!(pix_idx >= PPL && !switch_pending && !model_busy) && k < 8000) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_done_in_time"}, 32'(k < 8000), 32'd1);
        repeat (12) @(negedge clk);
    endtask

    task automatic check_line(input string tag, input int n_rd, input int a0, input int a1, input int n_end);
        check_eq({tag, "_pixels"}, 32'(pix_idx), 32'(PPL));
        check_eq({tag, "_rd_cnt"}, 32'(rd_cnt), 32'(n_rd));
        check_eq({tag, "_rd_addr0"}, 32'((rd_addr_q.size() > 0) ? rd_addr_q[0] : -1), 32'(a0));
        if (n_rd > 1)
            check_eq({tag, "_rd_addr1"}, 32'((rd_addr_q.size() > 1) ? rd_addr_q[1] : -1), 32'(a1));
        check_eq({tag, "_end_cnt"}, 32'(end_cnt), 32'(n_end));
        check_eq({tag, "_end_at_word"}, 32'(end_addr), 32'(cur_base + WPL - 2));
    endtask

    task automatic wait_model_n(input int n, input string tag);
        int k;
        k = 0;
        while (model_n < n && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_reached_word"}, 32'(k < 5000), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int y, y2, b1;
        reset = 1'b1; hblank = 1'b0; video_y = 10'd0; fifo_wrfull = 1'b0;
        repeat (4) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // First line: y=0 reads from 2160, single burst.
        start_line(0, NOCUT, "y0");
        wait_done("y0");
        check_line("y0", 1, 2160, -1, 1);
        check_eq("y0_overflow", 32'(overflow), 32'd0);

        // Last line wraps to address 0.
        start_line(LINES - 1, NOCUT, "wrap");
        wait_done("wrap");
        check_line("wrap", 1, 0, -1, 1);

        // Random lines.
        for (int i = 0; i < 2; i++) begin
            y = int'($urandom_range(0, LINES - 2));
            start_line(y, NOCUT, "rand");
            wait_done("rand");
            check_line("rand", 1, exp_base_of(y), -1, 1);
        end

        // Controller cuts the first burst at 1000 words; fetch resumes at base+1000.
        y = int'($urandom_range(0, LINES - 1));
        start_line(y, 1000, "cut");
        wait_done("cut");
        check_line("cut", 2, exp_base_of(y), exp_base_of(y) + 1000, 1);

        // New hblank edge around word 500 abandons the line and restarts at the new base.
        y  = int'($urandom_range(0, LINES - 1));
        y2 = int'($urandom_range(0, LINES - 1));
        b1 = exp_base_of(y);
        start_line(y, NOCUT, "flush");
        wait_model_n(500, "flush");
        @(negedge clk);
        video_y = 10'(y2);
        pending_base = exp_base_of(y2);
        switch_pending = 1;
        hblank = 1'b1;
        repeat (4) @(negedge clk);
        hblank = 1'b0;
        wait_done("flush");
        check_line("flush", 2, b1, exp_base_of(y2), 2);

        // FIFO full during a line sets overflow, which stays set until reset.
        fifo_wrfull = 1'b1;
        y = int'($urandom_range(0, LINES - 1));
        start_line(y, NOCUT, "ovf");
        wait_done("ovf");
        fifo_wrfull = 1'b0;
        check_eq("ovf_set", 32'(overflow), 32'd1);
        y = int'($urandom_range(0, LINES - 1));
        start_line(y, NOCUT, "ovf2");
        wait_done("ovf2");
        check_eq("ovf_sticky", 32'(overflow), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("ovf_reset");
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-burst: the remaining words must be ignored, with no new request.
        y = int'($urandom_range(0, LINES - 1));
        start_line(y, 1500, "rst");
        wait_model_n(600, "rst");
        @(negedge clk);
        reset = 1'b1;
        exp_active = 0;
        @(posedge clk);
        #1;
        check_zero("rst_mid");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wr_cnt = 0;
        rd_cnt = 0;
        for (int k = 0; k < 5000 && model_busy; k++) @(negedge clk);
        repeat (20) @(negedge clk);
        check_eq("rst_no_fifo_wr", 32'(wr_cnt), 32'd0);
        check_eq("rst_no_sd_rd", 32'(rd_cnt), 32'd0);

        // Normal operation resumes on the next edge.
        y = int'($urandom_range(0, LINES - 1));
        start_line(y, NOCUT, "recover");
        wait_done("recover");
        check_line("recover", 1, exp_base_of(y), -1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
